sm_ram_queue: RTL and testbench



---
 rtl/sm_ram_queue_pkg.sv | 41 ++++
 rtl/sm_fifo_sync.sv | 54 +++++
 rtl/sm_ram_queue.sv | 111 +++++++++++
 tb/tb_sm_ram_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sm_ram_queue_pkg.sv
// ============================================================================
// sm_ram_queue_pkg : shared settings, request record and byte-merge helper
// Rev 1.0
// ============================================================================
`default_nettype none

package sm_ram_queue_pkg;

  // Default access delay used by the top-level
  localparam int SM_CONFIG_BUSY_RAM_DELAY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } eng_state_t;

  // One queued request: addr 32 + wd 32 + be 4 + we 1 = 69 bits
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_fifo_sync.sv
// ============================================================================
// sm_fifo_sync : single-clock FIFO, power-of-2 depth, registered storage
// Rev 1.0
// ============================================================================
`default_nettype none

module sm_fifo_sync #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra MSB on each pointer distinguishes full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/sm_ram_queue.sv
// ============================================================================
// sm_ram_queue : data RAM with in-order request queue and fixed access delay
// Rev 1.0
// ============================================================================
`default_nettype none

module sm_ram_queue
  import sm_ram_queue_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DELAY = SM_CONFIG_BUSY_RAM_DELAY,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [31:0] rsp_rd
);

  localparam int          DELAY_C = (DELAY > 255) ? 255 : ((DELAY < 0) ? 0 : DELAY);
  localparam logic [7:0]  DELAY_L = 8'(DELAY_C);

  logic [31:0]      mem [2**WIDTH];

  eng_state_t       state;
  eng_state_t       state_nxt;
  logic [7:0]       cnt;
  req_t             cur;
  req_t             req_in;
  req_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             do_access;
  logic [WIDTH-1:0] idx;
  logic             unused_addr_bits;

  assign req_ready = ~rst & ~fifo_full;
  assign push      = req_valid & req_ready;
  assign req_in    = '{addr: req_addr, wd: req_wd, be: req_be, we: req_we};
  assign pop       = (state == IDLE) & ~fifo_empty;
  assign do_access = (state == WAIT) && (cnt == 8'd0);
  assign rsp_valid = (state == RESP);
  assign idx       = cur.addr[WIDTH+1:2];

  // Upper address bits alias and the byte offset is ignored
  assign unused_addr_bits = ^{cur.addr[31:WIDTH+2], cur.addr[1:0]};

  sm_fifo_sync #(
    .DATA_W (REQ_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (req_in),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = WAIT;
      WAIT:    if (cnt == 8'd0) state_nxt = RESP;
      RESP:    if (rsp_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      cur    <= '0;
      rsp_we <= 1'b0;
      rsp_rd <= 32'd0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        cur <= fifo_head;
        cnt <= DELAY_L;
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (do_access) begin
        rsp_we <= cur.we;
        rsp_rd <= cur.we ? 32'd0 : mem[idx];
      end
    end
  end

  // RAM has no reset; a reset on the access edge suppresses the write
  always_ff @(posedge clk) begin
    if (do_access && cur.we && !rst) mem[idx] <= be_merge(mem[idx], cur.wd, cur.be);
  end

endmodule

`default_nettype wire

// File: tb/tb_sm_ram_queue.sv
// ============================================================================
// tb_sm_ram_queue : directed vectors plus queue-full and reset sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sm_ram_queue;

  typedef struct {
    bit          sel;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          exp_we;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wd = '0;
  logic        rsp_ready = 1'b1;

  logic        v2_in, v0_in;
  logic        rdy2, rdy0, val2, val0, we2, we0;
  logic [31:0] rd2, rd0;
  logic        s_req_ready, s_rsp_valid, s_rsp_we;
  logic [31:0] s_rsp_rd;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign v2_in       = req_valid & ~sel;
  assign v0_in       = req_valid & sel;
  assign s_req_ready = sel ? rdy0 : rdy2;
  assign s_rsp_valid = sel ? val0 : val2;
  assign s_rsp_we    = sel ? we0  : we2;
  assign s_rsp_rd    = sel ? rd0  : rd2;

  sm_ram_queue #(.WIDTH(6), .DELAY(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(v2_in), .req_ready(rdy2),
    .req_addr(req_addr), .req_we(req_we), .req_be(req_be), .req_wd(req_wd),
    .rsp_valid(val2), .rsp_ready(rsp_ready), .rsp_we(we2), .rsp_rd(rd2)
  );

  sm_ram_queue #(.WIDTH(6), .DELAY(0), .DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0_in), .req_ready(rdy0),
    .req_addr(req_addr), .req_we(req_we), .req_be(req_be), .req_wd(req_wd),
    .rsp_valid(val0), .rsp_ready(rsp_ready), .rsp_we(we0), .rsp_rd(rd0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit s, input bit we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input int lat);
    vec_t v;
    v.sel = s; v.we = we; v.addr = addr; v.be = be; v.wd = wd;
    v.exp_we = we; v.exp_rd = exp_rd; v.exp_lat = lat;
    return v;
  endfunction

  // Offers one request; returns at #1 after the accepting edge
  task automatic push_req(input bit we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int max_wait, output bit ok);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wd = wd;
    ok = 1'b0;
    for (int k = 0; k < max_wait; k++) begin
      if (s_req_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    int lat;
    sel = v.sel;
    push_req(v.we, v.addr, v.be, v.wd, 20, ok);
    chk({tag, "_accept"}, {31'd0, ok}, 32'd1);
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      lat++;
      if (s_rsp_valid) break;
    end
    chk({tag, "_lat"}, lat, v.exp_lat);
    chk({tag, "_we"}, {31'd0, s_rsp_we}, {31'd0, v.exp_we});
    chk({tag, "_rd"}, s_rsp_rd, v.exp_rd);
    @(posedge clk); #1;
  endtask

  vec_t        vecs[$];
  logic [31:0] words[6];

  initial begin
    bit ok;
    int acks;
    bit accept_next;
    bit sixth_done;
    bit stray;

    vecs.push_back(mk(0, 1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0,        4));
    vecs.push_back(mk(0, 0, 32'h10,  4'hF, 32'h0,        32'hDEADBEEF, 4));
    vecs.push_back(mk(0, 1, 32'h08,  4'hF, 32'h11223344, 32'h0,        4));
    vecs.push_back(mk(0, 1, 32'h08,  4'h5, 32'hAABBCCDD, 32'h0,        4));
    vecs.push_back(mk(0, 0, 32'h08,  4'h0, 32'h0,        32'h11BB33DD, 4));
    vecs.push_back(mk(0, 1, 32'h14,  4'hF, 32'hCAFEF00D, 32'h0,        4));
    vecs.push_back(mk(0, 1, 32'h14,  4'h0, 32'h12345678, 32'h0,        4));
    vecs.push_back(mk(0, 0, 32'h14,  4'hF, 32'h0,        32'hCAFEF00D, 4));
    vecs.push_back(mk(0, 1, 32'h110, 4'hF, 32'h00000077, 32'h0,        4));
    vecs.push_back(mk(0, 0, 32'h013, 4'hF, 32'h0,        32'h00000077, 4));
    vecs.push_back(mk(1, 1, 32'h100, 4'hF, 32'h00000005, 32'h0,        2));
    vecs.push_back(mk(1, 0, 32'h000, 4'hF, 32'h0,        32'h00000005, 2));

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_rst", {31'd0, s_req_ready}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_ready", {31'd0, s_req_ready}, 32'd1);
      chk("idle_valid", {31'd0, s_rsp_valid}, 32'd0);
      chk("idle_rd", s_rsp_rd, 32'd0);
      chk("idle_we", {31'd0, s_rsp_we}, 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    sel = 1'b0;

    // Queue full and back-pressure
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) words[i] = 32'h1000_0000 + 32'(i) * 32'h111;
    for (int i = 0; i < 5; i++) begin
      push_req(1'b1, 32'(4 * i), 4'hF, words[i], 10, ok);
      chk($sformatf("full_accept%0d", i), {31'd0, ok}, 32'd1);
    end
    push_req(1'b1, 32'd20, 4'hF, words[5], 8, ok);
    chk("full_sixth_blocked", {31'd0, ok}, 32'd0);
    chk("full_ready_low", {31'd0, s_req_ready}, 32'd0);
    chk("full_rsp_held", {31'd0, s_rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    acks = 0;
    sixth_done = 1'b0;
    for (int c = 0; c < 200 && acks < 6; c++) begin
      if (s_rsp_valid) begin
        chk("full_ack_we", {31'd0, s_rsp_we}, 32'd1);
        chk("full_ack_rd", s_rsp_rd, 32'd0);
        acks++;
      end
      accept_next = req_valid && s_req_ready;
      @(posedge clk); #1;
      if (accept_next) begin
        req_valid = 1'b0;
        sixth_done = 1'b1;
      end
    end
    chk("full_ack_count", acks, 6);
    chk("full_sixth_taken", {31'd0, sixth_done}, 32'd1);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++)
      run_vec(mk(0, 0, 32'(4 * i), 4'hF, 32'h0, words[i], 4), $sformatf("full_rd%0d", i));

    // Reset mid-operation, landing on the first write's access edge
    for (int i = 1; i < 4; i++) begin
      push_req(1'b1, 32'(4 * i), 4'hF, 32'hFFFF_FFFF, 10, ok);
      chk($sformatf("rst_accept%0d", i), {31'd0, ok}, 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (s_rsp_valid) stray = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_no_stray_rsp", {31'd0, stray}, 32'd0);
    for (int i = 1; i < 4; i++)
      run_vec(mk(0, 0, 32'(4 * i), 4'hF, 32'h0, words[i], 4), $sformatf("rst_rd%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
